// File: rtl/mem_io_master.sv
// -----------------------------------------------------------------------------
// mem_io_master
//
// Single-outstanding initiator for the mem_io_* load/store handshake. Accepts
// one request from the LSU, drives the bus strobes toward a memory responder,
// waits for the responder's ready pulse and for ready to fall again, then
// returns exactly one response (extended load data or an error).
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both are high; valid, once raised, is held with its payload unchanged until
// that edge.
//
// Parameters:
//   XLEN            data/address width
//   TIMEOUT_CYCLES  cycles to wait for each mem_io_ready level (0 = never)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_*                       LSU request channel (valid/ready)
//   resp_*                      LSU response channel (valid/ready)
//   mem_io_addr/read/write/wdata, io_byte_size, mem_read_ready
//                               bus outputs toward the responder
//   mem_io_rdata, mem_io_ready  bus inputs from the responder
//   dbg_state                   current FSM state (0 IDLE, 1 ACCESS,
//                               2 RELEASE, 3 RESP)
//
// Optional build macro: MEM_IO_MASTER_ALIGN_CHECK_EN
//   When defined, size-3 and misaligned halfword/word requests are rejected
//   in IDLE with no bus activity and answered with resp_err = 1.
// -----------------------------------------------------------------------------
module mem_io_master #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_io_addr,
  output logic            mem_io_read,
  output logic            mem_io_write,
  output logic [XLEN-1:0] mem_io_wdata,
  output logic [1:0]      io_byte_size,
  output logic            mem_read_ready,
  input  logic [XLEN-1:0] mem_io_rdata,
  input  logic            mem_io_ready,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t          r_state;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [XLEN-1:0] r_resp_rdata;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_size;
  logic            r_is_write;
  logic            r_unsigned;
  logic            r_rd_strobe;
  logic            r_wr_strobe;
  logic [CW-1:0]   r_cnt;

  logic            w_reject;
  logic [CW-1:0]   w_cnt_next;
  logic            w_timeout;

`ifdef MEM_IO_MASTER_ALIGN_CHECK_EN
  assign w_reject = (req_size == 2'd3) ||
                    ((req_size == 2'd2) && req_addr[0]) ||
                    ((req_size == 2'd0) && (req_addr[1:0] != 2'b00));
`else
  assign w_reject = 1'b0;
`endif

  // Saturating increment; the timeout fires on the edge where the count
  // reaches TIMEOUT_CYCLES, so the strobe is high for exactly that many cycles.
  assign w_cnt_next = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next >= CW'(TIMEOUT_CYCLES));

  function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                               input logic [1:0]      sz,
                                               input logic            uns);
    logic [XLEN-1:0] v;
    case (sz)
      2'd1:    v = uns ? {{(XLEN-8){1'b0}}, d[7:0]}
                       : {{(XLEN-8){d[7]}}, d[7:0]};
      2'd2:    v = uns ? {{(XLEN-16){1'b0}}, d[15:0]}
                       : {{(XLEN-16){d[15]}}, d[15:0]};
      default: v = d;  // word, and size 3 passed through unextended
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'd0;
      r_is_write   <= 1'b0;
      r_unsigned   <= 1'b0;
      r_rd_strobe  <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_is_write  <= req_write;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            if (w_reject) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= S_RESP;
            end else begin
              r_addr      <= req_addr;
              r_wdata     <= req_wdata;
              r_rd_strobe <= ~req_write;
              r_wr_strobe <= req_write;
              r_cnt       <= '0;
              r_state     <= S_ACCESS;
            end
          end else begin
            // Also raises req_ready on the first edge after reset release.
            r_req_ready <= 1'b1;
          end
        end

        S_ACCESS: begin
          r_cnt <= w_cnt_next;
          if (mem_io_ready) begin
            r_rd_strobe <= 1'b0;
            r_wr_strobe <= 1'b0;
            if (!r_is_write)
              r_resp_rdata <= f_extend(mem_io_rdata, r_size, r_unsigned);
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end else if (w_timeout) begin
            r_rd_strobe  <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        // Strobes are already low; wait for the responder to drop ready so a
        // lingering ready level cannot complete the next access.
        S_RELEASE: begin
          r_cnt <= w_cnt_next;
          if (!mem_io_ready) begin
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;
  assign mem_io_addr    = r_addr;
  assign mem_io_wdata   = r_wdata;
  assign io_byte_size   = r_size;
  assign mem_io_read    = r_rd_strobe;
  assign mem_io_write   = r_wr_strobe;
  // The read strobe is high exactly while in ACCESS with a load.
  assign mem_read_ready = r_rd_strobe;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_io_master.sv
// -----------------------------------------------------------------------------
// tb_mem_io_master
//
// Directed bench for mem_io_master. u_dut uses the default timeout and talks
// to a behavioural responder that pulses ready for one cycle a programmable
// number of cycles after a strobe rises. u_dut_to uses TIMEOUT_CYCLES = 4 and
// a directly driven ready level to exercise both timeout paths.
// -----------------------------------------------------------------------------
module tb_mem_io_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- main DUT signals ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_io_addr;
  logic        mem_io_read;
  logic        mem_io_write;
  logic [31:0] mem_io_wdata;
  logic [1:0]  io_byte_size;
  logic        mem_read_ready;
  logic [31:0] mem_io_rdata;
  logic        mem_io_ready;
  logic [1:0]  dbg_state;

  // ---------------- responder model ----------------
  int          rsp_delay = 1;
  logic        rsp_enable = 1'b1;
  logic [31:0] rsp_data = '0;
  logic        rsp_ready_q = 1'b0;
  int          rsp_cnt = 0;
  logic        rsp_fired = 1'b0;
  logic        glitch = 1'b0;

  assign mem_io_ready = rsp_ready_q | glitch;
  assign mem_io_rdata = rsp_data;

  always @(posedge clk) begin
    if (!(mem_io_read || mem_io_write)) begin
      rsp_ready_q <= 1'b0;
      rsp_cnt     <= 0;
      rsp_fired   <= 1'b0;
    end else if (rsp_ready_q) begin
      rsp_ready_q <= 1'b0;
    end else if (rsp_enable && !rsp_fired) begin
      if (rsp_cnt + 1 >= rsp_delay) begin
        rsp_ready_q <= 1'b1;
        rsp_fired   <= 1'b1;
      end
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  mem_io_master u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_io_addr(mem_io_addr), .mem_io_read(mem_io_read),
    .mem_io_write(mem_io_write), .mem_io_wdata(mem_io_wdata),
    .io_byte_size(io_byte_size), .mem_read_ready(mem_read_ready),
    .mem_io_rdata(mem_io_rdata), .mem_io_ready(mem_io_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- timeout DUT ----------------
  logic        t_req_valid = 1'b0;
  logic        t_req_ready;
  logic        t_req_write = 1'b0;
  logic [31:0] t_req_addr = 32'h40;
  logic [31:0] t_req_wdata = 32'h0;
  logic [1:0]  t_req_size = 2'd0;
  logic        t_req_unsigned = 1'b0;
  logic        t_resp_valid;
  logic        t_resp_ready = 1'b0;
  logic [31:0] t_resp_rdata;
  logic        t_resp_err;
  logic [31:0] t_mem_io_addr;
  logic        t_mem_io_read;
  logic        t_mem_io_write;
  logic [31:0] t_mem_io_wdata;
  logic [1:0]  t_io_byte_size;
  logic        t_mem_read_ready;
  logic [31:0] t_mem_io_rdata = 32'hFFFF_FFFF;
  logic        t_mem_io_ready = 1'b0;
  logic [1:0]  t_dbg_state;

  mem_io_master #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .rst(rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(t_req_write),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_size(t_req_size),
    .req_unsigned(t_req_unsigned),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .mem_io_addr(t_mem_io_addr), .mem_io_read(t_mem_io_read),
    .mem_io_write(t_mem_io_write), .mem_io_wdata(t_mem_io_wdata),
    .io_byte_size(t_io_byte_size), .mem_read_ready(t_mem_read_ready),
    .mem_io_rdata(t_mem_io_rdata), .mem_io_ready(t_mem_io_ready),
    .dbg_state(t_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a request; returns at the first negedge after the accept edge.
  task automatic send_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] sz,
                          input logic uns);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = sz;
    req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts edges after accept until resp_valid, strobe-high cycles, and
  // whether bus outputs stayed constant while a strobe was high.
  task automatic wait_resp(input int limit, output int cycles,
                           output int strobes, output logic stable);
    logic [31:0] a0, d0;
    logic [1:0]  s0;
    logic        w0;
    a0 = mem_io_addr; d0 = mem_io_wdata; s0 = io_byte_size; w0 = mem_io_write;
    cycles  = 0;
    strobes = (mem_io_read || mem_io_write) ? 1 : 0;
    stable  = 1'b1;
    while (!resp_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (mem_io_read || mem_io_write) begin
        strobes++;
        if (mem_io_addr !== a0 || mem_io_wdata !== d0 ||
            io_byte_size !== s0 || mem_io_write !== w0)
          stable = 1'b0;
      end
    end
    if (!resp_valid) check("resp_valid_bound", 32'(resp_valid), 32'd1);
  endtask

  // Checks the response against the scoreboard, holds resp_ready low for
  // 'hold' cycles, then completes the handshake.
  task automatic take_resp(input int hold, input logic exp_err);
    logic [31:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    check("resp_rdata", resp_rdata, exp);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("resp_valid_held", 32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_clr", 32'(resp_valid), 32'd0);
    check("resp_rdata_clr", resp_rdata, 32'd0);
    check("resp_err_clr", 32'(resp_err), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  // Timeout DUT: one request with ready held at level rdy.
  task automatic to_run(input logic wr, input logic rdy,
                        input int exp_cyc, input int exp_stb);
    int cyc, stb;
    @(negedge clk);
    check("to_req_ready", 32'(t_req_ready), 32'd1);
    t_mem_io_ready = rdy;
    t_req_valid = 1'b1;
    t_req_write = wr;
    @(negedge clk);
    t_req_valid = 1'b0;
    check("to_strobe_on", 32'(t_mem_io_read | t_mem_io_write), 32'd1);
    cyc = 0;
    stb = (t_mem_io_read || t_mem_io_write) ? 1 : 0;
    while (!t_resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (t_mem_io_read || t_mem_io_write) stb++;
    end
    check("to_latency", 32'(cyc), 32'(exp_cyc));
    check("to_strobe_cycles", 32'(stb), 32'(exp_stb));
    check("to_resp_err", 32'(t_resp_err), 32'd1);
    check("to_resp_rdata", t_resp_rdata, 32'd0);
    t_mem_io_ready = 1'b0;
    t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
    check("to_resp_clr", 32'(t_resp_valid), 32'd0);
    check("to_req_ready_back", 32'(t_req_ready), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int   cyc, stb;
    logic stab;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", 32'({mem_io_read, mem_io_write}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready_rise", 32'(req_ready), 32'd1);

    // Word load, one-cycle responder
    rsp_delay = 1; rsp_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    send_req(1'b0, 32'h100, 32'h0, 2'd0, 1'b0);
    check("ld_addr", mem_io_addr, 32'h100);
    check("ld_read", 32'({mem_io_read, mem_io_write, mem_read_ready}), 32'b101);
    wait_resp(20, cyc, stb, stab);
    check("ld_latency", 32'(cyc), 32'd3);
    check("ld_strobe_cycles", 32'(stb), 32'd2);
    take_resp(0, 1'b0);

    // Load extension patterns: {size, unsigned, bus data, expected}
    begin
      logic [1:0]  sz_t[6]  = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
      logic        un_t[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] dat_t[6] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001,
                                32'hABCD_12F0, 32'h1234_F00F, 32'h5555_7FFE};
      logic [31:0] exp_t[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                32'h0000_00F0, 32'h0000_F00F, 32'h0000_7FFE};
      for (int i = 0; i < 6; i++) begin
        rsp_data = dat_t[i];
        exp_q.push_back(exp_t[i]);
        send_req(1'b0, 32'h204, 32'h0, sz_t[i], un_t[i]);
        check("ext_size", 32'(io_byte_size), 32'(sz_t[i]));
        wait_resp(20, cyc, stb, stab);
        take_resp(0, 1'b0);
      end
    end

    // Word store, five-cycle responder, response held off for 3 cycles
    rsp_delay = 5; rsp_data = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0);
    send_req(1'b1, 32'h20, 32'h1234_5678, 2'd0, 1'b0);
    check("st_write", 32'({mem_io_read, mem_io_write, mem_read_ready}), 32'b010);
    check("st_wdata", mem_io_wdata, 32'h1234_5678);
    check("st_addr", mem_io_addr, 32'h20);
    wait_resp(30, cyc, stb, stab);
    check("st_stable", 32'(stab), 32'd1);
    check("st_strobe_cycles", 32'(stb), 32'd6);
    check("st_latency", 32'(cyc), 32'd7);
    take_resp(3, 1'b0);
    rsp_delay = 1;

    // Ready high while idle must be ignored
    glitch = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_glitch_state", 32'(dbg_state), 32'd0);
    check("idle_glitch_resp", 32'(resp_valid), 32'd0);
    glitch = 1'b0;
    @(negedge clk);

    // Misaligned halfword load and size-3 load
`ifdef MEM_IO_MASTER_ALIGN_CHECK_EN
    exp_q.push_back(32'h0);
    send_req(1'b0, 32'h101, 32'h0, 2'd2, 1'b0);
    wait_resp(20, cyc, stb, stab);
    check("mis_latency", 32'(cyc), 32'd0);
    check("mis_strobes", 32'(stb), 32'd0);
    take_resp(0, 1'b1);
    exp_q.push_back(32'h0);
    send_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b0);
    wait_resp(20, cyc, stb, stab);
    check("sz3_strobes", 32'(stb), 32'd0);
    take_resp(0, 1'b1);
`else
    rsp_data = 32'h5555_7FFE;
    exp_q.push_back(32'h0000_7FFE);
    send_req(1'b0, 32'h101, 32'h0, 2'd2, 1'b0);
    check("mis_addr", mem_io_addr, 32'h101);
    wait_resp(20, cyc, stb, stab);
    check("mis_latency", 32'(cyc), 32'd3);
    take_resp(0, 1'b0);
    rsp_data = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    send_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b1);
    check("sz3_size", 32'(io_byte_size), 32'd3);
    wait_resp(20, cyc, stb, stab);
    take_resp(0, 1'b0);
`endif

    // Reset pulse during ACCESS
    rsp_enable = 1'b0;
    send_req(1'b0, 32'h300, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    check("mid_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_strobe", 32'(mem_io_read), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_hold", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_req_ready_rise", 32'(req_ready), 32'd1);
    check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    rsp_enable = 1'b1;

    // Timeout DUT: ACCESS timeout load, then store, then RELEASE timeout
    to_run(1'b0, 1'b0, 4, 4);
    to_run(1'b1, 1'b0, 4, 4);
    to_run(1'b0, 1'b1, 5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
